frame_buffer_arbiter: RTL and testbench

Responder end of the buffer request/acknowledge protocol used by the preprocessing blocks' buffer readers and writers. It owns one frame buffer (DEPTH × DATA_BITS) and arbitrates two read clients and two write clients, for example the VGA scan-out and a filter reader, or the camera capture and a filter writer. Each side grants exclusive access through `rq_*`/`ack_*` and multiplexes the granted client's address and data onto the storage.

---
 rtl/frame_buffer_arbiter.sv | 149 ++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer with request/acknowledge arbitration of two read clients and two write clients.
// Optional macro FB_FRAME_LOCK_EN makes the read and write sides mutually exclusive.
module frame_buffer_arbiter #(
    parameter int DEPTH     = 76800,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int DATA_BITS = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rq_read_a,
    input  logic                 rq_read_b,
    output logic                 ack_read_a,
    output logic                 ack_read_b,
    input  logic [ADDR_BITS-1:0] read_addr_a,
    input  logic [ADDR_BITS-1:0] read_addr_b,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 read_valid,
    input  logic                 rq_write_a,
    input  logic                 rq_write_b,
    output logic                 ack_write_a,
    output logic                 ack_write_b,
    input  logic [ADDR_BITS-1:0] write_addr_a,
    input  logic [ADDR_BITS-1:0] write_addr_b,
    input  logic [DATA_BITS-1:0] write_data_a,
    input  logic [DATA_BITS-1:0] write_data_b,
    input  logic                 write_en_a,
    input  logic                 write_en_b,
    output logic                 read_busy,
    output logic                 write_busy
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, RELEASE} arb_state_t;

    // last_b = 1 means client B was served last, so A wins the next tie.
    typedef struct packed {
        arb_state_t state;
        logic       last_b;
    } side_t;

    localparam side_t                SIDE_RESET  = '{state: IDLE, last_b: 1'b1};
    localparam logic [ADDR_BITS:0]   DEPTH_LIMIT = (ADDR_BITS + 1)'(DEPTH);

    function automatic side_t next_side(input side_t cur, input logic rq_a,
                                        input logic rq_b, input logic allow);
        side_t nxt;
        nxt = cur;
        case (cur.state)
            IDLE: begin
                if (allow) begin
                    if (rq_a && (!rq_b || cur.last_b)) nxt.state = GRANT_A;
                    else if (rq_b)                     nxt.state = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!rq_a) begin
                    nxt.state  = RELEASE;
                    nxt.last_b = 1'b0;
                end
            end
            GRANT_B: begin
                if (!rq_b) begin
                    nxt.state  = RELEASE;
                    nxt.last_b = 1'b1;
                end
            end
            default: nxt.state = IDLE;
        endcase
        return nxt;
    endfunction

    side_t rd_cur, rd_nxt, wr_cur, wr_nxt;
    logic  rd_allow, wr_allow;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_allow = 1'b1;
        wr_allow = 1'b1;
`ifdef FB_FRAME_LOCK_EN
        // The write side wins when both would leave IDLE on the same edge.
        wr_allow = (rd_cur.state == IDLE);
        rd_allow = (wr_cur.state == IDLE) && !(rq_write_a || rq_write_b);
`endif
        rd_nxt = next_side(rd_cur, rq_read_a, rq_read_b, rd_allow);
        wr_nxt = next_side(wr_cur, rq_write_a, rq_write_b, wr_allow);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cur <= SIDE_RESET;
            wr_cur <= SIDE_RESET;
        end else begin
            rd_cur <= rd_nxt;
            wr_cur <= wr_nxt;
        end
    end

    assign ack_read_a  = (rd_cur.state == GRANT_A);
    assign ack_read_b  = (rd_cur.state == GRANT_B);
    assign ack_write_a = (wr_cur.state == GRANT_A);
    assign ack_write_b = (wr_cur.state == GRANT_B);
    assign read_busy   = (rd_cur.state != IDLE);
    assign write_busy  = (wr_cur.state != IDLE);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 wr_we;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 rd_en;
    logic                 rd_in_range;
    logic [ADDR_BITS-1:0] rd_addr;

    always_comb begin
        wr_we   = 1'b0;
        wr_addr = write_addr_a;
        wr_data = write_data_a;
        if (wr_cur.state == GRANT_A) begin
            wr_we = write_en_a && ({1'b0, write_addr_a} < DEPTH_LIMIT);
        end else if (wr_cur.state == GRANT_B) begin
            wr_we   = write_en_b && ({1'b0, write_addr_b} < DEPTH_LIMIT);
            wr_addr = write_addr_b;
            wr_data = write_data_b;
        end

        rd_en   = (rd_cur.state == GRANT_A) || (rd_cur.state == GRANT_B);
        rd_addr = (rd_cur.state == GRANT_B) ? read_addr_b : read_addr_a;
        rd_in_range = ({1'b0, rd_addr} < DEPTH_LIMIT);
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_we) mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a same-edge write to the read address returns the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else if (rd_en) begin
            read_data  <= rd_in_range ? mem[rd_addr] : '0;
            read_valid <= 1'b1;
        end else begin
            read_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: directed scenarios plus randomized
// write/read sessions checked against a behavioural memory model.
module tb_frame_buffer_arbiter;

    localparam int DEPTH     = 76800;
    localparam int ADDR_BITS = 17;
    localparam int DATA_BITS = 15;
`ifdef FB_FRAME_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 rq_read_a, rq_read_b, ack_read_a, ack_read_b;
    logic [ADDR_BITS-1:0] read_addr_a, read_addr_b;
    logic [DATA_BITS-1:0] read_data;
    logic                 read_valid;
    logic                 rq_write_a, rq_write_b, ack_write_a, ack_write_b;
    logic [ADDR_BITS-1:0] write_addr_a, write_addr_b;
    logic [DATA_BITS-1:0] write_data_a, write_data_b;
    logic                 write_en_a, write_en_b;
    logic                 read_busy, write_busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_BITS-1:0] ref_mem [int];

    frame_buffer_arbiter #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .rq_read_a(rq_read_a), .rq_read_b(rq_read_b),
        .ack_read_a(ack_read_a), .ack_read_b(ack_read_b),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data(read_data), .read_valid(read_valid),
        .rq_write_a(rq_write_a), .rq_write_b(rq_write_b),
        .ack_write_a(ack_write_a), .ack_write_b(ack_write_b),
        .write_addr_a(write_addr_a), .write_addr_b(write_addr_b),
        .write_data_a(write_data_a), .write_data_b(write_data_b),
        .write_en_a(write_en_a), .write_en_b(write_en_b),
        .read_busy(read_busy), .write_busy(write_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rq_read_a = 0; rq_read_b = 0; rq_write_a = 0; rq_write_b = 0;
        write_en_a = 0; write_en_b = 0;
        read_addr_a = '0; read_addr_b = '0; write_addr_a = '0; write_addr_b = '0;
        write_data_a = '0; write_data_b = '0;
    endtask

    function automatic logic [DATA_BITS-1:0] ref_read(input int addr);
        if (addr >= DEPTH) return '0;
        return ref_mem[addr];
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        repeat (3) step();
        checks++;
        if ({ack_read_a, ack_read_b, ack_write_a, ack_write_b, read_valid, read_busy, write_busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {ack_read_a, ack_read_b, ack_write_a, ack_write_b, read_valid, read_busy, write_busy});
        end
        checks++;
        if (read_data !== '0) begin
            errors++; $display("FAIL reset_read_data: got %h want 0", read_data);
        end
        reset_n = 1;
        step();
        checks++;
        if ({ack_read_a, ack_read_b, ack_write_a, ack_write_b, read_busy, write_busy} !== 6'b0) begin
            errors++; $display("FAIL post_reset_idle: got %b want 000000",
                               {ack_read_a, ack_read_b, ack_write_a, ack_write_b, read_busy, write_busy});
        end
    endtask

    task automatic test_single_grant();
        rq_write_a = 1;
        step();
        checks++;
        if (ack_write_a !== 1'b1 || ack_write_b !== 1'b0) begin
            errors++; $display("FAIL single_grant_ack: got a=%b b=%b want a=1 b=0", ack_write_a, ack_write_b);
        end
        write_en_a = 1; write_addr_a = 17'd5; write_data_a = 15'h1234;
        step();
        ref_mem[5] = 15'h1234;
        write_addr_a = 17'd76799; write_data_a = 15'h7FFF;
        step();
        ref_mem[76799] = 15'h7FFF;
        write_en_a = 0; rq_write_a = 0;
        step();
        checks++;
        if (ack_write_a !== 1'b0 || write_busy !== 1'b1) begin
            errors++; $display("FAIL write_release: got ack=%b busy=%b want ack=0 busy=1", ack_write_a, write_busy);
        end
        step();
        checks++;
        if (write_busy !== 1'b0) begin
            errors++; $display("FAIL write_idle: got busy=%b want 0", write_busy);
        end

        rq_read_b = 1; read_addr_b = 17'd5;
        step();
        checks++;
        if (ack_read_b !== 1'b1 || read_valid !== 1'b0) begin
            errors++; $display("FAIL read_b_grant: got ack=%b valid=%b want ack=1 valid=0", ack_read_b, read_valid);
        end
        step();
        checks++;
        if (read_valid !== 1'b1 || read_data !== 15'h1234) begin
            errors++; $display("FAIL read_addr5: got valid=%b data=%h want valid=1 data=1234", read_valid, read_data);
        end
        read_addr_b = 17'd76799;
        step();
        checks++;
        if (read_valid !== 1'b1 || read_data !== 15'h7FFF) begin
            errors++; $display("FAIL read_addr_top: got valid=%b data=%h want valid=1 data=7fff", read_valid, read_data);
        end
        rq_read_b = 0;
        step();
        checks++;
        if (ack_read_b !== 1'b0 || read_valid !== 1'b1 || read_data !== 15'h7FFF) begin
            errors++; $display("FAIL read_release_edge: got ack=%b valid=%b data=%h want ack=0 valid=1 data=7fff",
                               ack_read_b, read_valid, read_data);
        end
        step();
        checks++;
        if (read_valid !== 1'b0 || read_data !== 15'h7FFF || read_busy !== 1'b0) begin
            errors++; $display("FAIL read_hold: got valid=%b data=%h busy=%b want valid=0 data=7fff busy=0",
                               read_valid, read_data, read_busy);
        end
    endtask

    task automatic test_tie_round_robin();
        rq_read_a = 1; rq_read_b = 1;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (ack_read_a !== 1'b1 || ack_read_b !== 1'b0) begin
                errors++; $display("FAIL tie_first_a cyc%0d: got a=%b b=%b want a=1 b=0", c, ack_read_a, ack_read_b);
            end
        end
        rq_read_a = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ack_read_a !== 1'b0 || ack_read_b !== (c == 2)) begin
                errors++; $display("FAIL tie_handover step%0d: got a=%b b=%b want a=0 b=%b",
                                   c, ack_read_a, ack_read_b, c == 2);
            end
        end
        // Serve A alone so that A is the last owner, then a tie must go to B.
        rq_read_b = 0;
        step(); step();
        rq_read_a = 1;
        step();
        rq_read_a = 0;
        step(); step();
        rq_read_a = 1; rq_read_b = 1;
        step();
        checks++;
        if (ack_read_b !== 1'b1 || ack_read_a !== 1'b0) begin
            errors++; $display("FAIL rr_b_first: got a=%b b=%b want a=0 b=1", ack_read_a, ack_read_b);
        end
        rq_read_b = 0;
        step(); step(); step();
        checks++;
        if (ack_read_a !== 1'b1 || ack_read_b !== 1'b0) begin
            errors++; $display("FAIL rr_a_second: got a=%b b=%b want a=1 b=0", ack_read_a, ack_read_b);
        end
        rq_read_a = 0;
        step(); step();
    endtask

    task automatic test_non_owner_range();
        rq_write_a = 1;
        step();
        write_en_a = 1; write_addr_a = 17'd7; write_data_a = 15'h0ABC;
        step();
        ref_mem[7] = 15'h0ABC;
        write_en_a = 0;
        rq_write_b = 1; write_en_b = 1; write_addr_b = 17'd7; write_data_b = 15'h7001;
        step();
        checks++;
        if (ack_write_a !== 1'b1 || ack_write_b !== 1'b0) begin
            errors++; $display("FAIL non_owner_ack: got a=%b b=%b want a=1 b=0", ack_write_a, ack_write_b);
        end
        rq_write_b = 0; write_en_b = 0;
        write_en_a = 1; write_addr_a = 17'd80000; write_data_a = 15'h5555;
        step();
        write_en_a = 0; rq_write_a = 0;
        step(); step();

        rq_read_a = 1; read_addr_a = 17'd7;
        step(); step();
        checks++;
        if (read_data !== ref_read(7)) begin
            errors++; $display("FAIL non_owner_mem7: got %h want %h", read_data, ref_read(7));
        end
        read_addr_a = 17'd80000;
        step();
        checks++;
        if (read_data !== 15'h0 || read_valid !== 1'b1) begin
            errors++; $display("FAIL out_of_range_read: got data=%h valid=%b want data=0 valid=1", read_data, read_valid);
        end
        rq_read_a = 0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        rq_write_a = 1; rq_read_b = 1; read_addr_b = 17'd5;
        step();
        checks++;
        if (ack_write_a !== 1'b1 || ack_read_b !== !LOCK) begin
            errors++; $display("FAIL pre_reset_acks: got w=%b r=%b want w=1 r=%b", ack_write_a, ack_read_b, !LOCK);
        end
        step();
        #3 reset_n = 0;
        #1;
        checks++;
        if ({ack_read_a, ack_read_b, ack_write_a, ack_write_b, read_valid, read_busy, write_busy} !== 7'b0
            || read_data !== '0) begin
            errors++; $display("FAIL mid_reset: got flags=%b data=%h want flags=0000000 data=0",
                               {ack_read_a, ack_read_b, ack_write_a, ack_write_b, read_valid, read_busy, write_busy},
                               read_data);
        end
        idle_inputs();
        #2 reset_n = 1;
        step();
        rq_read_a = 1; read_addr_a = 17'd5;
        step(); step();
        checks++;
        if (read_valid !== 1'b1 || read_data !== ref_read(5)) begin
            errors++; $display("FAIL mem_survives_reset: got valid=%b data=%h want valid=1 data=%h",
                               read_valid, read_data, ref_read(5));
        end
        rq_read_a = 0;
        step(); step();
    endtask

    task automatic test_frame_lock();
`ifdef FB_FRAME_LOCK_EN
        rq_write_b = 1;
        step();
        rq_read_a = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ack_write_b !== 1'b1 || ack_read_a !== 1'b0) begin
                errors++; $display("FAIL lock_hold cyc%0d: got w=%b r=%b want w=1 r=0", c, ack_write_b, ack_read_a);
            end
        end
        rq_write_b = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ack_read_a !== (c == 2)) begin
                errors++; $display("FAIL lock_release step%0d: got r=%b want %b", c, ack_read_a, c == 2);
            end
        end
        rq_read_a = 0;
        step(); step();
        rq_read_a = 1; rq_write_a = 1;
        step();
        checks++;
        if (ack_write_a !== 1'b1 || ack_read_a !== 1'b0) begin
            errors++; $display("FAIL lock_tie_write_wins: got w=%b r=%b want w=1 r=0", ack_write_a, ack_read_a);
        end
        rq_read_a = 0; rq_write_a = 0;
        step(); step();
`else
        rq_read_a = 1; rq_write_a = 1;
        read_addr_a = 17'd5; write_addr_a = 17'd5;
        step();
        checks++;
        if (ack_write_a !== 1'b1 || ack_read_a !== 1'b1) begin
            errors++; $display("FAIL concurrent_acks: got w=%b r=%b want w=1 r=1", ack_write_a, ack_read_a);
        end
        write_en_a = 1; write_data_a = 15'h2222;
        step();
        checks++;
        if (read_data !== ref_read(5)) begin
            errors++; $display("FAIL read_before_write: got %h want %h", read_data, ref_read(5));
        end
        ref_mem[5] = 15'h2222;
        write_en_a = 0;
        step();
        checks++;
        if (read_data !== ref_read(5)) begin
            errors++; $display("FAIL read_after_write: got %h want %h", read_data, ref_read(5));
        end
        rq_read_a = 0; rq_write_a = 0;
        step(); step();
`endif
    endtask

    function automatic logic [ADDR_BITS-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return ADDR_BITS'(DEPTH + $urandom_range(0, 50000));
        if (r == 1) return ADDR_BITS'(DEPTH - 1);
        return ADDR_BITS'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            bit client;
            int n;
            client = 1'($urandom_range(0, 1));
            if (client) rq_write_b = 1; else rq_write_a = 1;
            step();
            checks++;
            if ((client ? ack_write_b : ack_write_a) !== 1'b1) begin
                errors++; $display("FAIL rand_write_grant t%0d: got 0 want 1", t);
            end
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                logic [ADDR_BITS-1:0] a;
                logic [DATA_BITS-1:0] d;
                logic                 en;
                a = rand_addr(); d = DATA_BITS'($urandom); en = 1'($urandom_range(0, 1));
                if (client) begin
                    write_addr_b = a; write_data_b = d; write_en_b = en;
                    write_addr_a = ADDR_BITS'($urandom_range(0, 31));
                    write_data_a = DATA_BITS'($urandom); write_en_a = 1'($urandom_range(0, 1));
                end else begin
                    write_addr_a = a; write_data_a = d; write_en_a = en;
                    write_addr_b = ADDR_BITS'($urandom_range(0, 31));
                    write_data_b = DATA_BITS'($urandom); write_en_b = 1'($urandom_range(0, 1));
                end
                step();
                if (en && int'(a) < DEPTH) ref_mem[int'(a)] = d;
            end
            idle_inputs();
            step(); step();

            client = 1'($urandom_range(0, 1));
            if (client) rq_read_b = 1; else rq_read_a = 1;
            step();
            checks++;
            if ((client ? ack_read_b : ack_read_a) !== 1'b1) begin
                errors++; $display("FAIL rand_read_grant t%0d: got 0 want 1", t);
            end
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                logic [ADDR_BITS-1:0] a;
                a = rand_addr();
                if (int'(a) < DEPTH && !ref_mem.exists(int'(a))) a = ADDR_BITS'(DEPTH + 1);
                if (client) read_addr_b = a; else read_addr_a = a;
                step();
                checks++;
                if (read_valid !== 1'b1 || read_data !== ref_read(int'(a))) begin
                    errors++; $display("FAIL rand_read t%0d i%0d addr %0d: got valid=%b data=%h want valid=1 data=%h",
                                       t, i, a, read_valid, read_data, ref_read(int'(a)));
                end
            end
            idle_inputs();
            step(); step();
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_tie_round_robin();
        test_non_owner_range();
        test_reset_mid();
        test_frame_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
